// File: rtl/tuser_split_fsm.sv
// AXIS pass-through with a registered output stage and a one-entry skid buffer.
// The first-beat tuser of each packet is split out as a one-cycle tuple pulse.
module tuser_split_fsm #(
  parameter int DATA_WIDTH  = 256,
  parameter int KEEP_WIDTH  = 32,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                   tin_aclk,
  input  logic                   tin_arst,
  input  logic                   tin_avalid,
  output logic                   tin_aready,
  input  logic [DATA_WIDTH-1:0]  tin_adata,
  input  logic [KEEP_WIDTH-1:0]  tin_akeep,
  input  logic                   tin_atlast,
  input  logic [TUSER_WIDTH-1:0] tin_atuser,
  output logic                   tin_bvalid,
  input  logic                   tin_bready,
  output logic [DATA_WIDTH-1:0]  tin_bdata,
  output logic [KEEP_WIDTH-1:0]  tin_bkeep,
  output logic                   tin_btlast,
  output logic                   tin_valid,
  output logic [TUSER_WIDTH-1:0] tin_data,
  output logic [1:0]             dbg_state,
  output logic [31:0]            dbg_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WRDN = 2'b01
  } state_t;

  state_t                   state_reg;
  logic                     aready_reg;
  logic                     out_valid_reg;
  logic [DATA_WIDTH-1:0]    out_data_reg;
  logic [KEEP_WIDTH-1:0]    out_keep_reg;
  logic                     out_last_reg;
  logic                     skid_valid_reg;
  logic                     skid_valid_next;
  logic [DATA_WIDTH-1:0]    skid_data_reg;
  logic [KEEP_WIDTH-1:0]    skid_keep_reg;
  logic                     skid_last_reg;
  logic                     tuple_valid_reg;
  logic [TUSER_WIDTH-1:0]   tuple_data_reg;
  logic [31:0]              pkt_cnt_reg;

  logic accept;
  logic out_free;

  assign accept   = tin_avalid & aready_reg;
  assign out_free = ~out_valid_reg | tin_bready;

  // Skid can only fill when the output stage is held; any free output slot drains it.
  always_comb begin
    skid_valid_next = skid_valid_reg;
    if (out_free)
      skid_valid_next = 1'b0;
    else if (accept)
      skid_valid_next = 1'b1;
  end

  always_ff @(posedge tin_aclk or posedge tin_arst) begin
    if (tin_arst) begin
      aready_reg     <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_keep_reg  <= '0;
      skid_last_reg  <= 1'b0;
    end else begin
      aready_reg     <= ~skid_valid_next;
      skid_valid_reg <= skid_valid_next;
      if (out_free) begin
        if (skid_valid_reg) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= skid_data_reg;
          out_keep_reg  <= skid_keep_reg;
          out_last_reg  <= skid_last_reg;
        end else if (accept) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= tin_adata;
          out_keep_reg  <= tin_akeep;
          out_last_reg  <= tin_atlast;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        skid_data_reg <= tin_adata;
        skid_keep_reg <= tin_akeep;
        skid_last_reg <= tin_atlast;
      end
    end
  end

  // Packet framing FSM; tuple and packet count are registered alongside it.
  always_ff @(posedge tin_aclk or posedge tin_arst) begin
    if (tin_arst) begin
      state_reg       <= IDLE;
      tuple_valid_reg <= 1'b0;
      tuple_data_reg  <= '0;
      pkt_cnt_reg     <= '0;
    end else begin
      tuple_valid_reg <= 1'b0;
      if (accept && tin_atlast)
        pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tuple_valid_reg <= 1'b1;
            tuple_data_reg  <= tin_atuser;
            if (!tin_atlast)
              state_reg <= WRDN;
          end
        end
        WRDN: begin
          if (accept && tin_atlast)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tin_aready  = aready_reg;
  assign tin_bvalid  = out_valid_reg;
  assign tin_bdata   = out_data_reg;
  assign tin_bkeep   = out_keep_reg;
  assign tin_btlast  = out_last_reg;
  assign tin_valid   = tuple_valid_reg;
  assign tin_data    = tuple_data_reg;
  assign dbg_state   = state_reg;
  assign dbg_pkt_cnt = pkt_cnt_reg;

endmodule

// File: doc/tuser_split_fsm.md
TUSER_SPLIT_FSM -- requirements
Module: tuser_split_fsm

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, default 256, AXIS tdata width.
- KEEP_WIDTH, default 32, tkeep width (DATA_WIDTH/8).
- TUSER_WIDTH, default 128, tuser/tuple width.
REQ-002 Ports SHALL be, one per line:
- tin_aclk  in  1  sole clock.
- tin_arst  in  1  asynchronous active-high reset.
- tin_avalid  in  1  input AXIS valid.
- tin_aready  out  1  input AXIS ready.
- tin_adata  in  DATA_WIDTH  input beat data.
- tin_akeep  in  KEEP_WIDTH  input byte enables.
- tin_atlast  in  1  input last beat.
- tin_atuser  in  TUSER_WIDTH  input metadata, meaningful on first beat only.
- tin_bvalid  out  1  output AXIS valid.
- tin_bready  in  1  output AXIS ready.
- tin_bdata  out  DATA_WIDTH  output beat data.
- tin_bkeep  out  KEEP_WIDTH  output byte enables.
- tin_btlast  out  1  output last beat.
- tin_valid  out  1  tuple valid, one-cycle pulse per packet.
- tin_data  out  TUSER_WIDTH  tuple data, held until the next packet.
- dbg_state  out  2  current FSM state.
- dbg_pkt_cnt  out  32  count of packets whose last beat was accepted.
REQ-003 The block SHALL use one clock, tin_aclk; reset tin_arst SHALL be asynchronous and active-high.

Function
REQ-004 A beat SHALL be accepted when tin_avalid=1 and tin_aready=1 in the same cycle.
REQ-005 A beat SHALL be emitted when tin_bvalid=1 and tin_bready=1 in the same cycle.
REQ-006 The datapath SHALL be a registered output stage plus a one-entry skid buffer holding tdata/tkeep/tlast.
REQ-007 tin_aready SHALL equal NOT skid_full, registered, so it never depends combinationally on tin_bready.
REQ-008 An accepted beat SHALL appear on tin_b* exactly 1 cycle later when the output stage is empty or being emitted. Otherwise it SHALL enter the skid buffer.
REQ-009 When the output stage is emitted and the skid buffer is full, the skid entry SHALL move to the output stage and skid_full SHALL clear.
REQ-010 With tin_bready held at 1, throughput SHALL be one beat per cycle with no bubbles.
REQ-011 tin_b* SHALL hold stable while tin_bvalid=1 and tin_bready=0.
REQ-012 Beat order SHALL be preserved. tdata, tkeep and tlast SHALL pass through unmodified.
REQ-013 The FSM SHALL have two states, encoded on dbg_state:
- IDLE = 2'b00: awaiting the first beat of a packet.
- WRDN = 2'b01: mid-packet.
REQ-014 Transitions from IDLE: accepted beat with tlast=0 -> WRDN; accepted beat with tlast=1 -> stay IDLE (single-beat packet); no accepted beat -> stay IDLE.
REQ-015 Transitions from WRDN: accepted beat with tlast=1 -> IDLE; any other cycle -> stay WRDN.
REQ-016 On a first-beat acceptance (state IDLE), tin_data SHALL load tin_atuser and tin_valid SHALL be 1 the following cycle, i.e. the same cycle that beat first drives tin_b* when unstalled. tin_valid SHALL be 0 in all other cycles.
REQ-017 tin_atuser SHALL be ignored on non-first beats.
REQ-018 The tuple path SHALL have no backpressure; the consumer samples tin_data on tin_valid=1.
REQ-019 dbg_pkt_cnt SHALL increment by 1 on each accepted tlast=1 beat and SHALL wrap 0xFFFFFFFF -> 0.
REQ-020 A 2'b10 or 2'b11 state SHALL be unreachable; if entered, the FSM SHALL return to IDLE on the next cycle.

Reset
REQ-021 While tin_arst=1, outputs SHALL be:
- tin_aready=0, tin_bvalid=0, tin_bdata=0, tin_bkeep=0, tin_btlast=0.
- tin_valid=0, tin_data=0.
- dbg_state=2'b00, dbg_pkt_cnt=0.
- skid buffer empty.
REQ-022 tin_aready SHALL rise on the first clock edge after tin_arst deasserts.
REQ-023 Reset mid-packet SHALL discard buffered beats. The next accepted beat after reset SHALL be treated as a first beat.

Verification
REQ-024 Single beat: tdata=0xAB.., tkeep=0xFFFFFFFF, tlast=1, tuser=0x1234 with tin_bready=1 -> next cycle tin_bvalid=1, tin_btlast=1, tin_valid=1, tin_data=0x1234; dbg_state stays 00; dbg_pkt_cnt=1.
REQ-025 Four-beat packet, tuser=0xA5 on beat 0 and 0xFF on beats 1-3, bready=1 -> four consecutive output beats; single tin_valid pulse with tin_data=0xA5; dbg_state 00->01->01->01->00.
REQ-026 Backpressure: tin_bready=0 for 3 cycles mid-stream -> tin_aready falls after one extra beat is accepted; no beat lost or duplicated; tin_b* stable while stalled.
REQ-027 Back-to-back packets (1-beat then 2-beat, no gap) -> two tin_valid pulses 1 cycle apart carrying each packet's tuser; dbg_pkt_cnt=2.
REQ-028 Reset asserted in WRDN with skid full -> all outputs at reset values immediately; after release, a 1-beat packet is handled as in REQ-024.
REQ-029 dbg_pkt_cnt preloaded (forced) to 0xFFFFFFFF, one packet sent -> dbg_pkt_cnt=0.
